// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolver: default geometry and FSM encoding.
package csa_pkg;

  localparam int CSA_WIDTH_DEF = 32;
  localparam int CSA_CHUNK_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } csa_state_e;

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple adder with carry in/out, reused across every chunk of the resolver.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};

endmodule

// File: rtl/csa_resolver.sv
// Resolves a redundant (sum, carry) pair into a binary result, CHUNK bits per cycle.
//   state   | meaning
//   IDLE    | ready for a new pair
//   ADD     | resolving chunk idx_q, carry held in cy_q
//   DONE    | result valid, held until out_ready
module csa_resolver
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH_DEF,
  parameter int CHUNK = CSA_CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_geometry
    $error("csa_resolver: WIDTH must be a positive multiple of CHUNK");
  end

  csa_state_e       state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cy_q, cy_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] add_a, add_b, add_s;
  logic             add_c;

  assign add_a = sum_q[int'(idx_q)*CHUNK +: CHUNK];
  assign add_b = carry_q[int'(idx_q)*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a_i (add_a),
    .b_i (add_b),
    .c_i (cy_q),
    .s_o (add_s),
    .c_o (add_c)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sum_d   = in_sum;
          carry_d = in_carry;
          idx_d   = '0;
          cy_d    = 1'b0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        data_d[int'(idx_q)*CHUNK +: CHUNK] = add_s;
        cy_d  = add_c;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          ovf_d   = add_c;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      carry_q <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs come straight from the state register.
  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_DONE);
  assign out_data     = data_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: directed vectors plus a random pass under backpressure.
module tb_csa_resolver;

  localparam int WIDTH = 32;
  localparam int N     = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_overflow;

  csa_resolver #(.WIDTH(WIDTH), .CHUNK(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_carry     (in_carry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             ovf;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  logic bp_en       = 1'b0;
  logic ready_force = 1'b1;
  logic vld_prev    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sole driver of out_ready; changes land 2 time units after the rising edge.
  always @(posedge clk) begin
    #2;
    if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    else       out_ready = ready_force;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    chk_cnt++;
    $display("FAIL %s: got timeout required DUT event", name);
  endtask

  // Monitor: latency on each out_valid rise, data/overflow on each output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      vld_prev = 1'b0;
    end else begin
      if (out_valid && !vld_prev) begin
        if (sb.size() == 0) chk("unexpected_valid", {63'd0, out_valid}, 64'd0);
        else chk("latency", 64'(cyc - sb[0].acc), 64'(N));
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", {32'd0, out_data}, {32'd0, e.data});
        chk("out_overflow", {63'd0, out_overflow}, {63'd0, e.ovf});
      end
      vld_prev = out_valid;
    end
  end

  // Offers a pair and returns once it is accepted; in_valid is left high.
  task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c, output int waits);
    logic [WIDTH:0] r;
    exp_t e;
    in_sum   = s;
    in_carry = c;
    in_valid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 100) begin
        timeout_fail("accept_timeout");
        return;
      end
    end
    r      = {1'b0, s} + {1'b0, c};
    e.data = r[WIDTH-1:0];
    e.ovf  = r[WIDTH];
    e.acc  = cyc + 1;
    sb.push_back(e);
    last_acc = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    timeout_fail("wait_valid");
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    timeout_fail("drain");
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] stream_s [6];
  logic [WIDTH-1:0] stream_c [6];

  initial begin
    int w;
    int prev_acc;
    int seen;
    logic [WIDTH-1:0] rs, rc;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sum   = '0;
    in_carry = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {63'd0, in_ready},     64'd1);
    chk("rst_out_valid", {63'd0, out_valid},    64'd0);
    chk("rst_out_data",  {32'd0, out_data},     64'd0);
    chk("rst_out_ovf",   {63'd0, out_overflow}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single carry into chunk 1, then full ripple, then a carry out of every chunk.
    send(32'h0000_00FF, 32'h0000_0001, w);
    chk("first_accept_waits", 64'(w), 64'd0);
    in_valid = 1'b0;
    drain(50);
    send(32'hFFFF_FFFF, 32'h0000_0001, w);
    in_valid = 1'b0;
    drain(50);
    send(32'h8080_8080, 32'h8080_8080, w);
    in_valid = 1'b0;
    drain(50);

    // Hold the result in DONE while a second pair is offered.
    ready_force = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, w);
    in_sum   = 32'hA5A5_0000;
    in_carry = 32'h5A5B_0001;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_data",     {32'd0, out_data},     64'h2345_6789);
      chk("hold_ovf",      {63'd0, out_overflow}, 64'd0);
      chk("hold_in_ready", {63'd0, in_ready},     64'd0);
      chk("hold_valid",    {63'd0, out_valid},    64'd1);
    end
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    send(32'hA5A5_0000, 32'h5A5B_0001, w);
    chk("second_accept_delay", 64'(w), 64'd1);
    in_valid = 1'b0;
    drain(50);

    // Reset while chunk 2 is pending: the result must vanish.
    send(32'hDEAD_BEEF, 32'h0123_4567, w);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    void'(sb.pop_back());
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_out_data",  {32'd0, out_data},  64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {63'd0, in_ready},     64'd1);
    chk("release_out_data", {32'd0, out_data},     64'd0);
    chk("release_out_ovf",  {63'd0, out_overflow}, 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_stale_valid", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    send(32'h0000_0010, 32'h0000_0020, w);
    chk("accept_after_reset", 64'(w), 64'd0);
    in_valid = 1'b0;
    drain(50);

    // Streaming with in_valid and out_ready tied high.
    stream_s[0] = 32'h0000_0001; stream_c[0] = 32'h0000_0002;
    stream_s[1] = 32'hFFFF_0000; stream_c[1] = 32'h0001_0000;
    stream_s[2] = 32'h7FFF_FFFF; stream_c[2] = 32'h7FFF_FFFF;
    stream_s[3] = 32'h00FF_00FF; stream_c[3] = 32'h0001_0001;
    stream_s[4] = 32'hCAFE_F00D; stream_c[4] = 32'h3501_0FF3;
    stream_s[5] = 32'hFFFF_FFFF; stream_c[5] = 32'hFFFF_FFFF;
    prev_acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(stream_s[i], stream_c[i], w);
      if (i > 0) chk("stream_interval", 64'(last_acc - prev_acc), 64'(N + 2));
      prev_acc = last_acc;
    end
    in_valid = 1'b0;
    drain(80);

    // Random pairs under random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      rs = $urandom;
      rc = $urandom;
      send(rs, rc, w);
      in_valid = 1'b0;
    end
    bp_en = 1'b0;
    drain(400);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/csa_resolver.md
CSA_RESOLVER -- requirements
Module: csa_resolver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, giving the bits resolved per cycle; WIDTH SHALL be an integer multiple of CHUNK and CHUNK >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a redundant operand pair is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a pair.
REQ-007 The block SHALL have port in_sum, input, WIDTH bits: the redundant sum vector.
REQ-008 The block SHALL have port in_carry, input, WIDTH bits: the redundant carry vector, already weight-aligned with in_sum.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: (in_sum + in_carry) mod 2^WIDTH.
REQ-012 The block SHALL have port out_overflow, output, 1 bit: bit WIDTH of in_sum + in_carry.

Function
REQ-013 The block SHALL implement an FSM with exactly three states: IDLE, ADD and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; on a rising edge with in_valid=1, the block SHALL capture in_sum and in_carry, clear chunk index and chunk carry, and go to ADD.
REQ-015 On each rising edge in ADD, the block SHALL add chunk i of sum, chunk i of carry and the chunk carry, store the CHUNK-bit result into chunk i of out_data, update the chunk carry and increment i.
REQ-016 On the edge that resolves chunk N-1 (N = WIDTH/CHUNK), the block SHALL load the final chunk carry into out_overflow and go to DONE.
REQ-017 out_valid SHALL rise exactly N rising edges after the accepting edge (4 for the defaults).
REQ-018 In DONE, out_valid SHALL be 1, and out_data and out_overflow SHALL hold stable until a rising edge with out_ready=1, which SHALL return the FSM to IDLE.
REQ-019 in_ready SHALL be 0 in ADD and DONE; in_valid and the input buses SHALL be ignored in those states.
REQ-020 in_ready and out_valid SHALL be decoded from the state register only, with no combinational path from in_valid or out_ready.
REQ-021 With in_valid and out_ready held at 1, the block SHALL accept one pair every N+2 cycles.
REQ-022 Outside DONE, out_data SHALL show the partial or last result and SHALL be considered valid only while out_valid=1.
REQ-023 out_overflow SHALL be the true carry out of bit WIDTH-1, including the ripple through every chunk.

Reset
REQ-024 While rst_n=0, the block SHALL force state=IDLE, chunk index=0, chunk carry=0, out_data=0 and out_overflow=0, giving out_valid=0 and in_ready=1.
REQ-025 Reset asserted in ADD or DONE SHALL abort the operation immediately and discard the result; no out_valid pulse SHALL follow release.
REQ-026 After rst_n rises, the block SHALL accept a pair on the first rising edge with in_valid=1.

Structure
REQ-027 Shared package csa_pkg SHALL hold the state encoding constants and the default WIDTH and CHUNK values.
REQ-028 The block SHALL contain exactly one sub-module, chunk_adder: a CHUNK-bit adder with carry-in and carry-out, instantiated once and time-multiplexed across chunks.
REQ-029 The chunk index counter SHALL be clog2(N) bits wide, with a minimum of 1 bit.

Verification
REQ-030 The bench SHALL drive in_sum=0x000000FF, in_carry=0x00000001 and require out_data=0x00000100, out_overflow=0, with out_valid rising 4 edges after acceptance.
REQ-031 The bench SHALL drive in_sum=0xFFFFFFFF, in_carry=0x00000001 and require out_data=0x00000000, out_overflow=1 (full ripple).
REQ-032 The bench SHALL hold out_ready=0 for 5 cycles in DONE while offering a second pair, and require out_data held, in_ready=0 and the second pair not taken; after out_ready=1, the second pair SHALL be accepted 1 cycle later.
REQ-033 The bench SHALL pulse rst_n low while chunk 2 is in ADD, and require out_valid=0, out_data=0, in_ready=1 after release, with no stale result.
REQ-034 The bench SHALL tie in_valid=1 and out_ready=1 and require one result per 6 cycles, in order, with no loss.
REQ-035 The bench SHALL apply 1000 random pairs under random backpressure and require out_data and out_overflow to match a 33-bit reference sum.
